// File: rtl/lfsr_prng_stream.sv
// ============================================================================
// Module   : lfsr_prng_stream
// Brief    : Parametrised Fibonacci LFSR emitting one word per STEPS shifts over a
//            valid/ready stream, with runtime reseed, zero-seed substitution and period-wrap flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_prng_stream #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'hAA,
    parameter int               STEPS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed_in,
    input  logic             i_out_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_random,
    output logic             o_lockup,
    output logic             o_period_wrap
);

    localparam int               C_CNT_W     = $clog2(STEPS + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_SEED_SAFE = (SEED == '0) ? C_ONE : SEED;

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_prng_stream: WIDTH must be 3..32");
        end
        if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
            $error("lfsr_prng_stream: STEPS must be 1..WIDTH");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_seed;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_valid;
    logic [WIDTH-1:0]   r_random;
    logic               r_lockup;
    logic               r_wrap;

    logic               w_fb;
    logic [WIDTH-1:0]   w_q_next;
    logic               w_seed_zero;
    logic [WIDTH-1:0]   w_seed_safe;

    assign w_fb        = ^(r_q & TAPS);
    assign w_q_next    = {r_q[WIDTH-2:0], w_fb};
    assign w_seed_zero = (i_seed_in == '0);
    assign w_seed_safe = w_seed_zero ? C_ONE : i_seed_in;

    // Reseed wins over fill/hold; a word accepted on the same edge is simply gone either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_q      <= C_SEED_SAFE;
            r_seed   <= C_SEED_SAFE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_random <= '0;
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_lockup <= 1'b0;
            r_wrap   <= 1'b0;
            if (i_load) begin
                r_q      <= w_seed_safe;
                r_seed   <= w_seed_safe;
                r_cnt    <= '0;
                r_valid  <= 1'b0;
                r_state  <= S_FILL;
                r_lockup <= w_seed_zero;
            end else begin
                case (r_state)
                    S_FILL: begin
                        if (i_en) begin
                            r_q    <= w_q_next;
                            r_wrap <= (w_q_next == r_seed);
                            if (r_cnt == C_CNT_LAST) begin
                                r_cnt    <= '0;
                                r_random <= w_q_next;
                                r_valid  <= 1'b1;
                                r_state  <= S_HOLD;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (i_out_ready) begin
                            r_valid <= 1'b0;
                            r_state <= S_FILL;
                        end
                    end
                    default: r_state <= S_FILL;
                endcase
            end
        end
    end

    assign o_out_valid   = r_valid;
    assign o_random      = r_random;
    assign o_lockup      = r_lockup;
    assign o_period_wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_prng_stream.sv
// ============================================================================
// Module   : tb_lfsr_prng_stream
// Brief    : Scoreboard bench for lfsr_prng_stream (STEPS=1 and STEPS=8 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_prng_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, load, ready;
    logic [7:0] seed_in;
    logic       valid, lockup, wrap;
    logic [7:0] random;

    logic       en8, ready8;
    logic       valid8, lockup8, wrap8;
    logic [7:0] random8;

    int         n_pass  = 0;
    int         n_total = 0;
    int         ncyc    = 0;
    int         wrap_n  = 0;
    int         wrap_t[$];
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hAA), .STEPS(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_load(load), .i_seed_in(seed_in),
        .i_out_ready(ready), .o_out_valid(valid), .o_random(random),
        .o_lockup(lockup), .o_period_wrap(wrap)
    );

    lfsr_prng_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'hAA), .STEPS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_en(en8), .i_load(1'b0), .i_seed_in(8'h00),
        .i_out_ready(ready8), .o_out_valid(valid8), .o_random(random8),
        .o_lockup(lockup8), .o_period_wrap(wrap8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [7:0] lfsr_n(input logic [7:0] q, input int n);
        logic [7:0] s = q;
        for (int i = 0; i < n; i++) s = lfsr_next(s);
        return s;
    endfunction

    // Every accepted word is checked against the oldest expected one.
    always @(negedge clk) begin
        ncyc++;
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) check_eq("sb_underflow", 0, 1);
            else check_eq("word", {24'd0, random}, {24'd0, sb.pop_front()});
        end
        if (wrap === 1'b1) begin
            wrap_n++;
            wrap_t.push_back(ncyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check_eq({tag, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n = 0;
        while (valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid_seen"}, {31'd0, valid}, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; ready = 1'b0; seed_in = 8'h00;
        en8 = 1'b0; ready8 = 1'b0;
        tick();
        tick();
        check_eq("rst_valid",  {31'd0, valid},   0);
        check_eq("rst_random", {24'd0, random},  0);
        check_eq("rst_lockup", {31'd0, lockup},  0);
        check_eq("rst_wrap",   {31'd0, wrap},    0);
        check_eq("rst_valid8", {31'd0, valid8},  0);
        check_eq("rst_random8",{24'd0, random8}, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int total;
        int wdiff;

        // T1: default stream with ready high
        do_reset();
        sb.push_back(8'h55); sb.push_back(8'hAB); sb.push_back(8'h57);
        en = 1'b1; ready = 1'b1;
        tick();
        check_eq("t1_first_after_1_edge", {31'd0, valid}, 1);
        wait_empty(20, "t1");
        en = 1'b0;

        // T2: backpressure holds the word
        do_reset();
        en = 1'b1;
        wait_valid(10, "t2");
        for (int i = 0; i < 20; i++) begin
            check_eq("t2_hold_random", {24'd0, random}, 8'h55);
            tick();
        end
        check_eq("t2_hold_valid", {31'd0, valid}, 1);
        sb.push_back(8'h55); sb.push_back(8'hAB);
        ready = 1'b1;
        wait_empty(20, "t2");
        en = 1'b0;

        // T3: zero seed is replaced by 1 and flagged
        load = 1'b1; seed_in = 8'h00;
        tick();
        check_eq("t3_lockup_pulse", {31'd0, lockup}, 1);
        check_eq("t3_valid_low",    {31'd0, valid},  0);
        load = 1'b0;
        sb.push_back(8'h02); sb.push_back(8'h04); sb.push_back(8'h08); sb.push_back(8'h11);
        en = 1'b1;
        tick();
        check_eq("t3_lockup_clear", {31'd0, lockup}, 0);
        wait_empty(30, "t3");
        en = 1'b0;

        // T6: async reset between edges while holding a word
        do_reset();
        en = 1'b1;
        wait_valid(10, "t6");
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6_async_valid",  {31'd0, valid},  0);
        check_eq("t6_async_random", {24'd0, random}, 0);
        tick();
        rst_n = 1'b1;
        sb.push_back(8'h55); sb.push_back(8'hAB);
        ready = 1'b1;
        wait_empty(20, "t6");
        ready = 1'b0;

        // Reseed while holding: held word discarded, non-zero seed raises no lockup
        wait_valid(10, "t7");
        load = 1'b1; seed_in = 8'h80;
        tick();
        check_eq("t7_valid_dropped", {31'd0, valid},  0);
        check_eq("t7_no_lockup",     {31'd0, lockup}, 0);
        load = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h02);
        ready = 1'b1;
        wait_empty(20, "t7");
        en = 1'b0; ready = 1'b0;

        // T4: full period, wrap every 255 shifts (two cycles per shift here)
        do_reset();
        wrap_n = 0;
        wrap_t.delete();
        for (int i = 1; i <= 520; i++) sb.push_back(lfsr_n(8'hAA, i));
        en = 1'b1; ready = 1'b1;
        wait_empty(1200, "t4");
        en = 1'b0; ready = 1'b0;
        tick(); tick();
        check_eq("t4_wrap_count", wrap_n, 2);
        wdiff = (wrap_t.size() >= 2) ? (wrap_t[1] - wrap_t[0]) : 0;
        check_eq("t4_wrap_interval", wdiff, 510);

        // T5: STEPS=8, valid after exactly 8 enabled edges
        do_reset();
        en8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_eq("t5_valid_edge", {31'd0, valid8}, (k == 8) ? 1 : 0);
        end
        check_eq("t5_word1", {24'd0, random8}, {24'd0, lfsr_n(8'hAA, 8)});
        ready8 = 1'b1;
        tick();
        check_eq("t5_transfer", {31'd0, valid8}, 0);
        ready8 = 1'b0;
        total = 0;
        while (valid8 !== 1'b1 && total < 40) begin
            en8 = ((total % 3) != 2);
            tick();
            total++;
        end
        check_eq("t5_gated_delay", total, 11);
        check_eq("t5_word2", {24'd0, random8}, {24'd0, lfsr_n(8'hAA, 16)});
        en8 = 1'b0;

        tick();
        check_eq("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
